// File: rtl/rf_writeback.sv
// rf_writeback: register-file write-back stage.
// Arbitrates the load/long-latency result port (mem) and the ALU result
// port with fixed priority mem > alu. It accepts at most one result per
// rising edge and presents the write on registered outputs one cycle later.
// Build option RF_SCOREBOARD_EN: when defined, adds the busy (pending-write)
// scoreboard with source hazard outputs. When undefined, rsN_busy_o are
// tied to 0 and issue_* are ignored.
module rf_writeback (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        mem_valid_i,
   output logic        mem_ready_o,
   input  logic [4:0]  mem_rd_idx_i,
   input  logic [63:0] mem_data_i,

   input  logic        alu_valid_i,
   output logic        alu_ready_o,
   input  logic [4:0]  alu_rd_idx_i,
   input  logic [63:0] alu_data_i,

   output logic        rf_wr_en_o,
   output logic [4:0]  rf_rd_idx_o,
   output logic [63:0] rf_wr_data_o,

   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_idx_i,
   input  logic [4:0]  rs1_idx_i,
   input  logic [4:0]  rs2_idx_i,
   output logic        rs1_busy_o,
   output logic        rs2_busy_o
);

   logic        acc_valid;
   logic [4:0]  acc_idx;
   logic [63:0] acc_data;
   logic        acc_write;

   // Loads are always accepted; the ALU port yields whenever a load is valid.
   assign mem_ready_o = 1'b1;
   assign alu_ready_o = ~mem_valid_i;

   // Fixed-priority selection of the single result accepted this edge.
   always_comb begin
      acc_valid = 1'b0;
      acc_idx   = '0;
      acc_data  = '0;
      if (mem_valid_i) begin
         acc_valid = 1'b1;
         acc_idx   = mem_rd_idx_i;
         acc_data  = mem_data_i;
      end else if (alu_valid_i) begin
         acc_valid = 1'b1;
         acc_idx   = alu_rd_idx_i;
         acc_data  = alu_data_i;
      end
   end

   // Results targeting x0 are consumed but never produce a write.
   assign acc_write = acc_valid && (acc_idx != '0);

   // Write port register: strobe lasts one cycle; index/data hold otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_wr_en_o   <= 1'b0;
         rf_rd_idx_o  <= '0;
         rf_wr_data_o <= '0;
      end else begin
         rf_wr_en_o <= acc_write;
         if (acc_write) begin
            rf_rd_idx_o  <= acc_idx;
            rf_wr_data_o <= acc_data;
         end
      end
   end

`ifdef RF_SCOREBOARD_EN
   logic [31:1] busy_q;
   logic [31:1] busy_d;
   logic [31:0] busy_full;

   // Busy update: clear on the write leaving the port, then set on issue so
   // a same-index issue in the same cycle keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned k = 1; k < 32; k++) begin
         if (rf_wr_en_o && (rf_rd_idx_o == k[4:0])) begin
            busy_d[k] = 1'b0;
         end
         if (issue_valid_i && (issue_rd_idx_i == k[4:0])) begin
            busy_d[k] = 1'b1;
         end
      end
   end

   // Busy vector register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Bit 0 is a constant 0 so x0 always reads not busy.
   assign busy_full  = {busy_q, 1'b0};
   assign rs1_busy_o = busy_full[rs1_idx_i];
   assign rs2_busy_o = busy_full[rs2_idx_i];
`else
   logic unused_sb;

   assign unused_sb  = ^{issue_valid_i, issue_rd_idx_i, rs1_idx_i, rs2_idx_i};
   assign rs1_busy_o = 1'b0;
   assign rs2_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: scoreboard bench for rf_writeback. A reference model
// predicts the write-port contents after every edge and queues them; a
// monitor pops and compares one entry per cycle. The busy model follows
// the RF_SCOREBOARD_EN build option.
module tb_rf_writeback;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic [4:0]  mem_rd_idx_i;
   logic [63:0] mem_data_i;
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_idx_i;
   logic [63:0] alu_data_i;
   logic        rf_wr_en_o;
   logic [4:0]  rf_rd_idx_o;
   logic [63:0] rf_wr_data_o;
   logic        issue_valid_i;
   logic [4:0]  issue_rd_idx_i;
   logic [4:0]  rs1_idx_i;
   logic [4:0]  rs2_idx_i;
   logic        rs1_busy_o;
   logic        rs2_busy_o;

   rf_writeback dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .mem_valid_i    (mem_valid_i),
      .mem_ready_o    (mem_ready_o),
      .mem_rd_idx_i   (mem_rd_idx_i),
      .mem_data_i     (mem_data_i),
      .alu_valid_i    (alu_valid_i),
      .alu_ready_o    (alu_ready_o),
      .alu_rd_idx_i   (alu_rd_idx_i),
      .alu_data_i     (alu_data_i),
      .rf_wr_en_o     (rf_wr_en_o),
      .rf_rd_idx_o    (rf_rd_idx_o),
      .rf_wr_data_o   (rf_wr_data_o),
      .issue_valid_i  (issue_valid_i),
      .issue_rd_idx_i (issue_rd_idx_i),
      .rs1_idx_i      (rs1_idx_i),
      .rs2_idx_i      (rs2_idx_i),
      .rs1_busy_o     (rs1_busy_o),
      .rs2_busy_o     (rs2_busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit        en;
      bit [4:0]  idx;
      bit [63:0] data;
   } wr_t;

   wr_t       exp_q[$];
   int        checks = 0;
   int        errors = 0;
   bit        busy_m[32];
   bit        alu_pending;
   bit [4:0]  last_idx;
   bit [63:0] last_data;
   wr_t       cur;

`ifdef RF_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: one predicted write-port state per edge out of reset.
   always @(posedge clk_i) begin
      if (!rst_ni) begin
         exp_q.delete();
         cur         = '{1'b0, 5'd0, 64'd0};
         alu_pending = 1'b0;
         last_idx    = '0;
         last_data   = '0;
         foreach (busy_m[i]) busy_m[i] = 1'b0;
      end else begin
         bit        acc;
         bit [4:0]  idx;
         bit [63:0] data;
         wr_t       e;
         if (SB) begin
            if (cur.en) busy_m[cur.idx] = 1'b0;
            if (issue_valid_i && issue_rd_idx_i != 0) busy_m[issue_rd_idx_i] = 1'b1;
         end
         acc = 1'b1;
         if (mem_valid_i) begin
            idx = mem_rd_idx_i; data = mem_data_i;
         end else if (alu_valid_i) begin
            idx = alu_rd_idx_i; data = alu_data_i;
         end else begin
            acc = 1'b0; idx = '0; data = '0;
         end
         if (acc && idx != 0) begin
            last_idx  = idx;
            last_data = data;
         end
         e = '{acc && idx != 0, last_idx, last_data};
         alu_pending = alu_valid_i && mem_valid_i;
         exp_q.push_back(e);
         cur = e;
      end
   end

   // Monitor: compare the write port and hazard outputs each cycle.
   initial begin
      forever begin
         wr_t e;
         @(posedge clk_i);
         #1;
         check("mem_ready", mem_ready_o, 1);
         check("alu_ready", alu_ready_o, !mem_valid_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_en",   rf_wr_en_o,   e.en);
            check("rd_idx",  rf_rd_idx_o,  e.idx);
            check("wr_data", rf_wr_data_o, e.data);
         end
         check("rs1_busy", rs1_busy_o, SB && rs1_idx_i != 0 && busy_m[rs1_idx_i]);
         check("rs2_busy", rs2_busy_o, SB && rs2_idx_i != 0 && busy_m[rs2_idx_i]);
      end
   end

   task automatic drive(input bit mv, input bit [4:0] mi, input bit [63:0] md,
                        input bit av, input bit [4:0] ai, input bit [63:0] ad,
                        input bit iv, input bit [4:0] ii, input bit [4:0] r1, input bit [4:0] r2);
      @(negedge clk_i);
      mem_valid_i = mv; mem_rd_idx_i = mi; mem_data_i = md;
      alu_valid_i = av; alu_rd_idx_i = ai; alu_data_i = ad;
      issue_valid_i = iv; issue_rd_idx_i = ii;
      rs1_idx_i = r1; rs2_idx_i = r2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, rs1_idx_i, rs2_idx_i);
   endtask

   task automatic rand_cycle();
      @(negedge clk_i);
      mem_valid_i    = ($urandom_range(0, 9) < 3);
      mem_rd_idx_i   = 5'($urandom_range(0, 31));
      mem_data_i     = {$urandom, $urandom};
      if (!alu_pending) begin
         alu_valid_i  = ($urandom_range(0, 9) < 6);
         alu_rd_idx_i = 5'($urandom_range(0, 31));
         alu_data_i   = {$urandom, $urandom};
      end
      issue_valid_i  = ($urandom_range(0, 9) < 4);
      issue_rd_idx_i = 5'($urandom_range(0, 31));
      rs1_idx_i      = 5'($urandom_range(0, 31));
      rs2_idx_i      = 5'($urandom_range(0, 31));
   endtask

   initial begin
      rst_ni = 1'b0;
      mem_valid_i = 0; mem_rd_idx_i = 0; mem_data_i = 0;
      alu_valid_i = 0; alu_rd_idx_i = 0; alu_data_i = 0;
      issue_valid_i = 0; issue_rd_idx_i = 0; rs1_idx_i = 0; rs2_idx_i = 0;

      // Results and issues presented during reset must be ignored.
      drive(1, 6, 64'h55, 1, 8, 64'h66, 1, 6, 6, 8);
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_wr_en",   rf_wr_en_o,   0);
      check("rst_rd_idx",  rf_rd_idx_o,  0);
      check("rst_wr_data", rf_wr_data_o, 0);
      check("rst_rs1",     rs1_busy_o,   0);
      idle();
      rst_ni = 1'b1;

      // Single ALU write.
      drive(0, 0, 0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 5, 0);
      idle();
      idle();

      // Collision: mem wins, alu holds and goes next.
      drive(1, 3, 64'h11, 1, 4, 64'h22, 0, 0, 3, 4);
      #1 check("coll_alu_ready", alu_ready_o, 0);
      drive(0, 0, 0, 1, 4, 64'h22, 0, 0, 3, 4);
      idle();
      idle();

      // x0 result is consumed and dropped.
      drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
      #1 check("x0_mem_ready", mem_ready_o, 1);
      idle();
      idle();

      // Scoreboard set and clear on write-back of x7.
      drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      @(posedge clk_i);
      #1 check("busy7_set", rs1_busy_o, SB);
      drive(0, 0, 0, 1, 7, 64'h77, 0, 0, 7, 0);
      idle();
      idle();
      idle();

      // Issue of x9 coinciding with x9 leaving the write port keeps it busy.
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      drive(0, 0, 0, 1, 9, 64'h99, 0, 0, 9, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      @(posedge clk_i);
      #1 check("busy9_kept", rs1_busy_o, SB);
      idle();
      idle();

      repeat (600) rand_cycle();
      idle();
      idle();

      // Asynchronous reset during an active write.
      drive(0, 0, 0, 1, 5, 64'hCAFE_0000_1234_5678, 1, 7, 7, 5);
      @(posedge clk_i);
      #2;
      check("pre_rst_wr_en", rf_wr_en_o, 1);
      rst_ni = 1'b0;
      exp_q.delete();
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      #1;
      check("async_wr_en",   rf_wr_en_o,   0);
      check("async_rd_idx",  rf_rd_idx_o,  0);
      check("async_wr_data", rf_wr_data_o, 0);
      check("async_rs1",     rs1_busy_o,   0);
      check("async_rs2",     rs2_busy_o,   0);
      drive(0, 0, 0, 1, 6, 64'h1, 1, 7, 7, 6);
      drive(0, 0, 0, 1, 6, 64'h1, 1, 7, 7, 6);
      rst_ni = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 6);
      idle();
      repeat (100) rand_cycle();
      idle();
      idle();

      @(negedge clk_i);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
